// File: rtl/io_bus_arbiter.sv
// Shares the single IO bus master port between NUM_MASTERS requesters, one transaction at a time.
// Round-robin by default; define IO_ARB_FIXED_PRIO_EN for fixed priority (master 0 highest).
module io_bus_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int NUM_IO_CORES = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_MASTERS-1:0]                     req_valid,
  input  logic [NUM_MASTERS-1:0]                     req_wr,
  input  logic [NUM_MASTERS-1:0][NUM_IO_CORES-1:0]   req_cs,
  input  logic [NUM_MASTERS-1:0][31:0]               req_address,
  input  logic [NUM_MASTERS-1:0][31:0]               req_wr_data,
  output logic [NUM_MASTERS-1:0]                     req_gnt,
  output logic [NUM_MASTERS-1:0]                     rsp_valid,
  output logic [31:0]                                rsp_rd_data,
  output logic                                       io_bus_m_rd_en,
  output logic                                       io_bus_m_wr_en,
  output logic [NUM_IO_CORES-1:0]                    io_bus_m_cs,
  output logic [31:0]                                io_bus_m_address,
  output logic [31:0]                                io_bus_m_wr_data,
  input  logic [31:0]                                io_bus_m_rd_data
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state, state_nxt;
  logic [MW-1:0] win;
  logic [MW-1:0] cur_m;
  logic          any_req;
  logic          gnt_ok;

`ifdef IO_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last writer.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req_valid[MW'(i)]) begin
        win     = MW'(i);
        any_req = 1'b1;
      end
    end
  end
`else
  logic [MW-1:0] rr_ptr;
  logic [MW-1:0] idx;

  always_comb begin
    win     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = MW'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (!any_req && req_valid[idx]) begin
        win     = idx;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rr_ptr <= '0;
    else if (gnt_ok)
      rr_ptr <= (win == MW'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;
  end
`endif

  // Grant is a same-cycle pulse, held off while reset is asserted.
  assign gnt_ok = rst && (state == IDLE) && any_req;

  always_comb begin
    req_gnt = '0;
    if (gnt_ok) req_gnt[win] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = io_bus_m_rd_en ? RESP : IDLE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_bus_m_rd_en   <= 1'b0;
      io_bus_m_wr_en   <= 1'b0;
      io_bus_m_cs      <= '0;
      io_bus_m_address <= '0;
      io_bus_m_wr_data <= '0;
      cur_m            <= '0;
      rsp_valid        <= '0;
      rsp_rd_data      <= '0;
    end else begin
      io_bus_m_rd_en <= 1'b0;
      io_bus_m_wr_en <= 1'b0;
      rsp_valid      <= '0;
      // cs/address/wr_data hold between grants so they stay stable through RESP.
      if (gnt_ok) begin
        io_bus_m_rd_en   <= ~req_wr[win];
        io_bus_m_wr_en   <= req_wr[win];
        io_bus_m_cs      <= req_cs[win];
        io_bus_m_address <= req_address[win];
        io_bus_m_wr_data <= req_wr_data[win];
        cur_m            <= win;
      end
      if (state == RESP) begin
        rsp_rd_data      <= io_bus_m_rd_data;
        rsp_valid[cur_m] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed vectors, corner sequences, randomized run vs. a schedule model.
module tb_io_bus_arbiter;
  localparam int NM = 2;
  localparam int NC = 3;

  logic                    clk, rst;
  logic [NM-1:0]           req_valid, req_wr, req_gnt, rsp_valid;
  logic [NM-1:0][NC-1:0]   req_cs;
  logic [NM-1:0][31:0]     req_address, req_wr_data;
  logic [31:0]             rsp_rd_data, io_bus_m_address, io_bus_m_wr_data, io_bus_m_rd_data;
  logic                    io_bus_m_rd_en, io_bus_m_wr_en;
  logic [NC-1:0]           io_bus_m_cs;

  int total = 0;
  int bad   = 0;

  io_bus_arbiter #(.NUM_MASTERS(NM), .NUM_IO_CORES(NC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_cs(req_cs),
    .req_address(req_address), .req_wr_data(req_wr_data),
    .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data),
    .io_bus_m_rd_en(io_bus_m_rd_en), .io_bus_m_wr_en(io_bus_m_wr_en),
    .io_bus_m_cs(io_bus_m_cs), .io_bus_m_address(io_bus_m_address),
    .io_bus_m_wr_data(io_bus_m_wr_data), .io_bus_m_rd_data(io_bus_m_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus slave: returns address halves swapped, 0 for an empty chip-select; garbage outside RESP.
  function automatic logic [31:0] bus_f(input logic [31:0] a, input logic [NC-1:0] c);
    return (c == '0) ? 32'h0 : {a[15:0], a[31:16]};
  endfunction

  logic           pend;
  logic [31:0]    pa;
  logic [NC-1:0]  pc;
  initial begin
    io_bus_m_rd_data = 32'h0;
    forever begin
      @(negedge clk);
      pend = io_bus_m_rd_en;
      pa   = io_bus_m_address;
      pc   = io_bus_m_cs;
      @(posedge clk);
      #1;
      io_bus_m_rd_data = pend ? bus_f(pa, pc) : $urandom;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs;
    req_valid = '0; req_wr = '0; req_cs = '0; req_address = '0; req_wr_data = '0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    idle_reqs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  32'(req_gnt), 32'h0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rspd"}, rsp_rd_data, 32'h0);
    chk({tag, "_rd"},   32'(io_bus_m_rd_en), 32'h0);
    chk({tag, "_wr"},   32'(io_bus_m_wr_en), 32'h0);
    chk({tag, "_cs"},   32'(io_bus_m_cs), 32'h0);
    chk({tag, "_addr"}, io_bus_m_address, 32'h0);
    chk({tag, "_wdat"}, io_bus_m_wr_data, 32'h0);
  endtask

  typedef struct {
    int          m;
    logic        wr;
    logic [2:0]  cs;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [NM-1:0] onehot;
    onehot = NM'(1 << v.m);
    cyc();                                  // cycle N
    req_valid[v.m] = 1'b1; req_wr[v.m] = v.wr; req_cs[v.m] = v.cs;
    req_address[v.m] = v.addr; req_wr_data[v.m] = v.wdata;
    @(negedge clk);
    chk("vec_gnt", 32'(req_gnt), 32'(onehot));
    chk("vec_nostrobe", {30'h0, io_bus_m_rd_en, io_bus_m_wr_en}, 32'h0);
    cyc();                                  // N+1: payload scrambled, must not matter
    req_valid = '0; req_address[v.m] = ~v.addr; req_wr_data[v.m] = ~v.wdata; req_cs[v.m] = ~v.cs;
    @(negedge clk);
    chk("vec_strobe", {30'h0, io_bus_m_rd_en, io_bus_m_wr_en}, v.wr ? 32'h1 : 32'h2);
    chk("vec_cs", 32'(io_bus_m_cs), 32'(v.cs));
    chk("vec_addr", io_bus_m_address, v.addr);
    if (v.wr) chk("vec_wdata", io_bus_m_wr_data, v.wdata);
    cyc();                                  // N+2
    @(negedge clk);
    chk("vec_n2_strobe", {30'h0, io_bus_m_rd_en, io_bus_m_wr_en}, 32'h0);
    chk("vec_n2_rspv", 32'(rsp_valid), 32'h0);
    cyc();                                  // N+3
    @(negedge clk);
    chk("vec_n3_rspv", 32'(rsp_valid), v.wr ? 32'h0 : 32'(onehot));
    if (!v.wr) chk("vec_n3_rspd", rsp_rd_data, v.exp_rd);
    cyc();
    @(negedge clk);
    chk("vec_n4_rspv", 32'(rsp_valid), 32'h0);
  endtask

  // Reference-model state for the randomized run: a slot schedule keyed by cycle.
  int             free_at, ptr;
  bit             sl_v  [8];
  logic           sl_wr [8];
  logic [NC-1:0]  sl_cs [8];
  logic [31:0]    sl_a  [8];
  logic [31:0]    sl_d  [8];
  logic [NM-1:0]  rs_v  [8];
  logic [31:0]    rs_d  [8];
  logic [31:0]    last_rd;
  logic [NM-1:0]  last_gnt;

  task automatic new_req(input int m);
    int r;
    r = $urandom_range(0, 3);
    req_valid[m]   = 1'b1;
    req_wr[m]      = 1'($urandom_range(0, 1));
    req_cs[m]      = (r == 3) ? '0 : NC'(1 << r);
    req_address[m] = $urandom;
    req_wr_data[m] = $urandom;
  endtask

  vec_t tbl[5];
  int   gidx[$];
  int   gcyc[$];

  initial begin
    tbl[0] = '{0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1, 1'b0, 3'b100, 32'h00A5_0000, 32'h0,         32'h0000_00A5};
    tbl[2] = '{0, 1'b0, 3'b001, 32'hCAFE_F00D, 32'h0,         32'hF00D_CAFE};
    tbl[3] = '{1, 1'b0, 3'b000, 32'h1234_5678, 32'h0,         32'h0};
    tbl[4] = '{1, 1'b1, 3'b100, 32'h0000_0010, 32'h1357_9BDF, 32'h0};

    // Reset state, with both masters requesting writes so gnt gating is visible.
    rst = 1'b0;
    idle_reqs();
    req_valid = '1; req_wr = '1;
    req_cs[0] = 3'b001; req_address[0] = 32'h10; req_wr_data[0] = 32'hA0;
    req_cs[1] = 3'b010; req_address[1] = 32'h20; req_wr_data[1] = 32'hB0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");

    // Contention straight out of reset.
    @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 20 && gidx.size() < 4; c++) begin
      @(negedge clk);
      for (int m = 0; m < NM; m++)
        if (req_gnt[m]) begin gidx.push_back(m); gcyc.push_back(c); end
      @(posedge clk);
      #1;
    end
    idle_reqs();
    chk("cont_count", 32'(gidx.size()), 32'd4);
    for (int i = 0; i < gidx.size(); i++) begin
`ifdef IO_ARB_FIXED_PRIO_EN
      chk("cont_order", 32'(gidx[i]), 32'd0);
`else
      chk("cont_order", 32'(gidx[i]), 32'(i % 2));
`endif
      if (i > 0) chk("cont_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd2);
    end
    repeat (3) cyc();

    foreach (tbl[i]) run_vec(tbl[i]);

    // Back-to-back: write then read with req_valid held.
    cyc();
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_cs[0] = 3'b001;
    req_address[0] = 32'h0000_0100; req_wr_data[0] = 32'h1111_2222;
    @(negedge clk); chk("bb_gnt_w", 32'(req_gnt), 32'h1);
    cyc();
    req_wr[0] = 1'b0; req_cs[0] = 3'b010; req_address[0] = 32'h0042_0000;
    @(negedge clk);
    chk("bb_issue_wr", 32'(io_bus_m_wr_en), 32'h1);
    chk("bb_issue_gnt", 32'(req_gnt), 32'h0);
    cyc();
    @(negedge clk); chk("bb_gnt_r", 32'(req_gnt), 32'h1);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("bb_rd_en", 32'(io_bus_m_rd_en), 32'h1);
    chk("bb_rd_addr", io_bus_m_address, 32'h0042_0000);
    cyc();
    @(negedge clk); chk("bb_n4_rspv", 32'(rsp_valid), 32'h0);
    cyc();
    @(negedge clk);
    chk("bb_rspv", 32'(rsp_valid), 32'h1);
    chk("bb_rspd", rsp_rd_data, 32'h0000_0042);
    cyc();

    // Late request: m1 arrives during m0's ISSUE, payload changes before its grant.
    cyc();
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_cs[0] = 3'b001;
    req_address[0] = 32'h200; req_wr_data[0] = 32'hAAAA_5555;
    @(negedge clk); chk("late_gnt0", 32'(req_gnt), 32'h1);
    cyc();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_cs[1] = 3'b100;
    req_address[1] = 32'h300; req_wr_data[1] = 32'h3333;
    @(negedge clk); chk("late_wait", 32'(req_gnt), 32'h0);
    cyc();
    req_address[1] = 32'h304; req_wr_data[1] = 32'h4444;
    @(negedge clk); chk("late_gnt1", 32'(req_gnt), 32'h2);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("late_wr", 32'(io_bus_m_wr_en), 32'h1);
    chk("late_addr", io_bus_m_address, 32'h304);
    chk("late_wdata", io_bus_m_wr_data, 32'h4444);
    chk("late_cs", 32'(io_bus_m_cs), 32'h4);
    repeat (2) cyc();

    // Reset asserted during RESP of a read.
    cyc();
    req_valid[1] = 1'b1; req_wr[1] = 1'b0; req_cs[1] = 3'b010; req_address[1] = 32'h00C3_0000;
    @(negedge clk); chk("rmr_gnt", 32'(req_gnt), 32'h2);
    cyc();
    req_valid = '0;
    @(negedge clk); chk("rmr_rd_en", 32'(io_bus_m_rd_en), 32'h1);
    cyc();
    #2 rst = 1'b0;
    #1 chk_all_zero("rmr_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rmr_no_rspv", 32'(rsp_valid), 32'h0);
      chk("rmr_rspd", rsp_rd_data, 32'h0);
      cyc();
    end
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_cs[0] = 3'b001; req_address[0] = 32'h8;
    @(negedge clk); chk("rmr_idle_gnt", 32'(req_gnt), 32'h1);
    cyc();
    idle_reqs();
    repeat (2) cyc();

    // Randomized traffic against the schedule model.
    do_reset();
    free_at = 0; ptr = 0; last_rd = 32'h0; last_gnt = '0;
    for (int s = 0; s < 8; s++) begin sl_v[s] = 1'b0; rs_v[s] = '0; end
    for (int t = 0; t < 600; t++) begin
      int            sl, w;
      logic [NM-1:0] exp_g;
      cyc();
      for (int m = 0; m < NM; m++) begin
        if (last_gnt[m]) begin
          if ($urandom_range(0, 1) == 1) new_req(m);
          else req_valid[m] = 1'b0;
        end else if (!req_valid[m]) begin
          if ($urandom_range(0, 9) < 4) new_req(m);
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[m] = 1'b0;
        end
      end
      @(negedge clk);
      sl = t % 8;
      chk("rnd_wr", 32'(io_bus_m_wr_en), 32'(sl_v[sl] && sl_wr[sl]));
      chk("rnd_rd", 32'(io_bus_m_rd_en), 32'(sl_v[sl] && !sl_wr[sl]));
      if (sl_v[sl]) begin
        chk("rnd_cs", 32'(io_bus_m_cs), 32'(sl_cs[sl]));
        chk("rnd_addr", io_bus_m_address, sl_a[sl]);
        if (sl_wr[sl]) chk("rnd_wdata", io_bus_m_wr_data, sl_d[sl]);
      end
      if (rs_v[sl] != '0) last_rd = rs_d[sl];
      chk("rnd_rspv", 32'(rsp_valid), 32'(rs_v[sl]));
      chk("rnd_rspd", rsp_rd_data, last_rd);
      sl_v[sl] = 1'b0; rs_v[sl] = '0;

      exp_g = '0;
      w = -1;
      if (t >= free_at) begin
        for (int k = 0; k < NM; k++) begin
          int i;
`ifdef IO_ARB_FIXED_PRIO_EN
          i = k;
`else
          i = (ptr + k) % NM;
`endif
          if (w < 0 && req_valid[i]) w = i;
        end
      end
      if (w >= 0) begin
        exp_g[w] = 1'b1;
        sl_v[(t+1)%8]  = 1'b1;
        sl_wr[(t+1)%8] = req_wr[w];
        sl_cs[(t+1)%8] = req_cs[w];
        sl_a[(t+1)%8]  = req_address[w];
        sl_d[(t+1)%8]  = req_wr_data[w];
        if (!req_wr[w]) begin
          rs_v[(t+3)%8] = NM'(1 << w);
          rs_d[(t+3)%8] = bus_f(req_address[w], req_cs[w]);
        end
        free_at = t + (req_wr[w] ? 2 : 3);
        ptr = (w + 1) % NM;
      end
      chk("rnd_gnt", 32'(req_gnt), 32'(exp_g));
      last_gnt = req_gnt;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single IO bus master port between NUM_MASTERS requesters (e.g. core LSU, debug/DMA engine).
- Sits between the requesters and io_interconnect; drives its io_bus_m_* inputs and consumes io_bus_m_rd_data.
- Serialises one transaction at a time, round-robin by default.
- Returns read data to the originating requester one cycle after the bus strobe, matching the interconnect's registered read-select.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..4).
- NUM_IO_CORES, from defines, width of the one-hot chip-select.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_MASTERS  per-master request
- req_wr  in  NUM_MASTERS  1=write, 0=read
- req_cs  in  NUM_MASTERS*NUM_IO_CORES  per-master one-hot chip-select, master m at slice m
- req_address  in  NUM_MASTERS*32  per-master address
- req_wr_data  in  NUM_MASTERS*32  per-master write data
- req_gnt  out  NUM_MASTERS  one-cycle accept pulse; at most one bit set
- rsp_valid  out  NUM_MASTERS  one-cycle read-data-valid pulse; at most one bit set
- rsp_rd_data  out  32  read data, shared by all masters, qualified by rsp_valid
- io_bus_m_rd_en  out  1  bus read strobe
- io_bus_m_wr_en  out  1  bus write strobe
- io_bus_m_cs  out  NUM_IO_CORES  bus chip-select
- io_bus_m_address  out  32  bus address
- io_bus_m_wr_data  out  32  bus write data
- io_bus_m_rd_data  in  32  bus read data; valid the cycle after io_bus_m_rd_en

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE; rr pointer=0.
  - All outputs 0: req_gnt, rsp_valid, rsp_rd_data, strobes, cs, address, wr_data.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid is set, select winner w by round-robin, starting the search at the rr pointer.
  - In the same cycle: req_gnt[w]=1; capture the request into the bus output registers; rr pointer = (w+1) mod NUM_MASTERS; go to ISSUE.
  - If no request: remain in IDLE with all strobes 0.
- ISSUE (exactly one cycle):
  - Registered bus outputs are driven; exactly one of rd_en/wr_en is 1.
  - Write: go to IDLE.
  - Read: go to RESP; remember w.
- RESP (exactly one cycle):
  - Strobes 0, cs/address held.
  - Capture io_bus_m_rd_data into rsp_rd_data; rsp_valid[w]=1 on the next cycle (registered); go to IDLE.
- rsp_rd_data holds its last value until the next read response.
- Latency, from the gnt cycle N:
  - Bus strobe at N+1.
  - Read response at N+3.
  - Throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Handshake:
  - A master holds req_* stable until it sees req_gnt.
  - Payload is sampled only in the gnt cycle.
  - req_valid may drop at any time before gnt without effect.
  - req_valid may stay high after gnt to issue a back-to-back request.
- Arbitration: arbitration occurs only in IDLE; requests arriving in ISSUE/RESP wait.
- Simultaneous requests: the lowest index at or after the rr pointer wins; no master is starved beyond NUM_MASTERS-1 transactions.
- cs is forwarded unchanged; zero or multi-hot cs is not checked. A cs=0 read returns the slot-0 data (0).
- Reset mid-operation: an in-flight read is dropped; no rsp_valid is produced after rst deasserts.

Optional Feature:
- IO_ARB_FIXED_PRIO_EN defined:
  - Round-robin is replaced by fixed priority; master 0 is highest.
  - rr pointer logic is removed.
  - Master NUM_MASTERS-1 may starve.
- Undefined: round-robin as above.

Test Plan:
- Reset: rst=0 mid-read (state RESP) -> all outputs 0 immediately; after release, no rsp_valid; IDLE.
- Single write: m0 write cs=3'b010, addr=0x8000_0004, data=0xDEAD_BEEF at cycle N -> req_gnt[0] at N; wr_en=1 with those values at N+1 only; IDLE at N+2.
- Single read: m1 read cs=3'b100, bus returns 0x0000_00A5 at N+2 -> rsp_valid[1]=1, rsp_rd_data=0xA5 at N+3; rd_en high only at N+1.
- Contention: m0 and m1 both continuously request from reset:
  - Default: gnt order 0,1,0,1.
  - With IO_ARB_FIXED_PRIO_EN: 0,0,0.
- Back-to-back: m0 issues write then read, req_valid held high -> gnts at N and N+2; read strobe at N+3; response at N+5.
- Late request: m1 asserts req_valid during m0's ISSUE cycle -> m1 granted only in the next IDLE cycle; its payload is sampled there.
